sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arb_pkg.sv | 23 ++
 rtl/sdram_arb_if.sv | 24 ++
 rtl/sdram_arb_tag_fifo.sv | 49 ++++
 rtl/sdram_arbiter.sv | 97 +++++++++
 tb/tb_sdram_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared widths, master-ID type, arbiter state codes and the tie-break rule for the SDRAM arbiter.
package sdram_arb_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef logic mid_t;
  localparam mid_t MID_M0 = 1'b0;
  localparam mid_t MID_M1 = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_G0   = 2'd1;
  localparam state_t ST_G1   = 2'd2;

  // On a tie the master that was not granted last wins.
  function automatic state_t pick(input logic r0, input logic r1, input mid_t lg);
    if (r0 && r1) return (lg == MID_M0) ? ST_G1 : ST_G0;
    if (r0) return ST_G0;
    if (r1) return ST_G1;
    return ST_IDLE;
  endfunction
endpackage

// File: rtl/sdram_arb_if.sv
// Avalon-style word port: command from the requester side, read data/valid and waitrequest back.
interface sdram_arb_if;
  import sdram_arb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable_n;
  logic              chipselect;
  logic [DATA_W-1:0] writedata;
  logic              read_n;
  logic              write_n;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, byteenable_n, chipselect, writedata, read_n, write_n,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable_n, chipselect, writedata, read_n, write_n,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// Generic ring FIFO holding the IDs of reads still awaiting data; head is combinational (no read latency).
// Push is ignored when full and pop when empty; the caller is expected to stall rather than overflow.
module sdram_arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Two-master arbiter onto one SDRAM controller port; read returns are routed back via an ID FIFO.
// Grant is registered (command appears one cycle after the request in IDLE); stalls follow s waitrequest and a full tag FIFO.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int TAG_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  sdram_arb_if.slave  m0,
  sdram_arb_if.slave  m1,
  sdram_arb_if.master s,
  output logic        err_orphan
);
  state_t state;
  state_t state_nxt;
  mid_t   last_grant;
  mid_t   last_grant_nxt;
  mid_t   gnt_id;
  mid_t   tag_head;
  logic   req0, req1, granted;
  logic   g_cs, g_rd_n, g_wr_n, g_wr, g_rd, g_req;
  logic   blocked, active, accept;
  logic   tag_full, tag_empty, ret_ok;

  assign req0    = m0.chipselect & (~m0.read_n | ~m0.write_n);
  assign req1    = m1.chipselect & (~m1.read_n | ~m1.write_n);
  assign granted = (state == ST_G0) | (state == ST_G1);
  assign gnt_id  = (state == ST_G1) ? MID_M1 : MID_M0;

  assign g_cs   = gnt_id ? m1.chipselect : m0.chipselect;
  assign g_rd_n = gnt_id ? m1.read_n     : m0.read_n;
  assign g_wr_n = gnt_id ? m1.write_n    : m0.write_n;
  // Both strobes low is treated as a write.
  assign g_wr   = g_cs & ~g_wr_n;
  assign g_rd   = g_cs & g_wr_n & ~g_rd_n;
  assign g_req  = g_wr | g_rd;

  // Full is judged on the registered count, so a pop in the same cycle does not release the stall.
  assign blocked = granted & g_rd & tag_full;
  assign active  = granted & g_req & ~blocked;
  assign accept  = active & ~s.waitrequest;

  assign s.chipselect   = active;
  assign s.read_n       = ~(active & g_rd);
  assign s.write_n      = ~(active & g_wr);
  assign s.address      = gnt_id ? m1.address      : m0.address;
  assign s.byteenable_n = gnt_id ? m1.byteenable_n : m0.byteenable_n;
  assign s.writedata    = gnt_id ? m1.writedata    : m0.writedata;

  assign m0.waitrequest   = (state == ST_G0) ? (blocked | s.waitrequest) : 1'b1;
  assign m1.waitrequest   = (state == ST_G1) ? (blocked | s.waitrequest) : 1'b1;
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign ret_ok           = s.readdatavalid & ~tag_empty;
  assign m0.readdatavalid = ret_ok & (tag_head == MID_M0);
  assign m1.readdatavalid = ret_ok & (tag_head == MID_M1);

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    if (!granted) begin
      state_nxt = pick(req0, req1, last_grant);
    end else if (accept) begin
      last_grant_nxt = gnt_id;
      state_nxt      = pick(req0, req1, gnt_id);
    end else if (!g_req) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= MID_M1;
      err_orphan <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (s.readdatavalid && tag_empty) err_orphan <= 1'b1;
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (1)
  ) u_tags (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (accept & g_rd),
    .pop      (ret_ok),
    .push_dat (gnt_id),
    .head     (tag_head),
    .full     (tag_full),
    .empty    (tag_empty)
  );
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench: reset, directed table, multi-cycle corner sequences, then random traffic against a queue model.
module tb_sdram_arbiter;
  localparam int          DEPTH = 8;
  localparam logic [21:0] A0  = 22'h000010;
  localparam logic [21:0] A1  = 22'h2AAAAA;
  localparam logic [31:0] D0  = 32'h0000A0A0;
  localparam logic [31:0] D1  = 32'h1111B1B1;
  localparam logic [3:0]  BE0 = 4'h0;
  localparam logic [3:0]  BE1 = 4'hA;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_orphan;
  int   checks = 0;
  int   errors = 0;

  sdram_arb_if m0();
  sdram_arb_if m1();
  sdram_arb_if s();

  sdram_arbiter #(.TAG_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m0         (m0),
    .m1         (m1),
    .s          (s),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  stim;   // {cs0, read_n0, write_n0, cs1, read_n1, write_n1, s_waitrequest}
    logic [2:0]  cmd;    // expected {s_chipselect, s_read_n, s_write_n} one cycle later
    logic [21:0] addr;
    logic [1:0]  wt;     // expected {m0_waitrequest, m1_waitrequest}
  } vec_t;
  vec_t tbl [8];

  // Random-phase model state
  logic        pend [2];
  logic        p_rd [2];
  logic [21:0] p_a  [2];
  logic [31:0] p_d  [2];
  int          age  [2];
  int          max_age;
  int          q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv(input int m, input logic cs, input logic rd_n, input logic wr_n,
                     input logic [21:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0.chipselect = cs; m0.read_n = rd_n; m0.write_n = wr_n;
      m0.address = a; m0.writedata = d; m0.byteenable_n = BE0;
    end else begin
      m1.chipselect = cs; m1.read_n = rd_n; m1.write_n = wr_n;
      m1.address = a; m1.writedata = d; m1.byteenable_n = BE1;
    end
  endtask

  task automatic idle_all();
    drv(0, 1'b0, 1'b1, 1'b1, A0, D0);
    drv(1, 1'b0, 1'b1, 1'b1, A1, D1);
  endtask

  function automatic logic wait_of(input int m);
    return (m == 0) ? m0.waitrequest : m1.waitrequest;
  endfunction

  // Inputs are driven at posedge+1, outputs sampled at posedge+4.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_all();
    s.readdatavalid = 1'b0;
    s.waitrequest   = 1'b0;
    s.readdata      = '0;
    nxt();
    reset_n = 1'b1;
  endtask

  task automatic issue_read(input int m);
    logic ok;
    ok = 1'b0;
    drv(m, 1'b1, 1'b0, 1'b1, (m == 0) ? A0 : A1, 32'h0);
    for (int i = 0; i < 20 && !ok; i++) begin
      #3;
      ok = !wait_of(m);
      nxt();
    end
    drv(m, 1'b0, 1'b1, 1'b1, (m == 0) ? A0 : A1, 32'h0);
    chk("issue_read_accepted", ok, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_cs"},   s.chipselect, 1'b0);
    chk({tag, "_s_rd_n"}, s.read_n, 1'b1);
    chk({tag, "_s_wr_n"}, s.write_n, 1'b1);
    chk({tag, "_wait"},   {m0.waitrequest, m1.waitrequest}, 2'b11);
    chk({tag, "_rdv"},    {m0.readdatavalid, m1.readdatavalid}, 2'b00);
    chk({tag, "_orphan"}, err_orphan, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] dat [4];
    int          who [4];
    logic        acc, exp_done, rdv;

    tbl[0] = '{7'b1010110, 3'b101, A0, 2'b01};  // m0 read alone
    tbl[1] = '{7'b0111100, 3'b110, A1, 2'b10};  // m1 write alone
    tbl[2] = '{7'b1011100, 3'b101, A0, 2'b01};  // tie: m0 wins first
    tbl[3] = '{7'b1000110, 3'b110, A0, 2'b01};  // both strobes low -> write
    tbl[4] = '{7'b0011110, 3'b011, A0, 2'b11};  // no valid request
    tbl[5] = '{7'b0011010, 3'b101, A1, 2'b10};  // m0 strobe without chipselect
    tbl[6] = '{7'b1011011, 3'b101, A0, 2'b11};  // tie, controller stalling
    tbl[7] = '{7'b0111001, 3'b110, A1, 2'b11};  // m1 write, stalling

    // Reset state while m0 requests and a stray return is presented
    reset_n = 1'b0;
    idle_all();
    drv(0, 1'b1, 1'b0, 1'b1, A0, D0);
    s.readdatavalid = 1'b1;
    s.waitrequest   = 1'b0;
    s.readdata      = 32'h12345678;
    #12;
    chk_reset_outputs("reset");

    for (int i = 0; i < 8; i++) begin
      do_reset();
      v = tbl[i];
      drv(0, v.stim[6], v.stim[5], v.stim[4], A0, D0);
      drv(1, v.stim[3], v.stim[2], v.stim[1], A1, D1);
      s.waitrequest = v.stim[0];
      #3;
      chk($sformatf("vec%0d_idle_cs", i), s.chipselect, 1'b0);
      chk($sformatf("vec%0d_idle_wait", i), {m0.waitrequest, m1.waitrequest}, 2'b11);
      nxt();
      #3;
      chk($sformatf("vec%0d_cmd", i), {s.chipselect, s.read_n, s.write_n}, v.cmd);
      chk($sformatf("vec%0d_wait", i), {m0.waitrequest, m1.waitrequest}, v.wt);
      if (v.cmd[2]) begin
        chk($sformatf("vec%0d_addr", i), s.address, v.addr);
        chk($sformatf("vec%0d_wdata", i), s.writedata, (v.addr == A0) ? D0 : D1);
        chk($sformatf("vec%0d_be", i), s.byteenable_n, (v.addr == A0) ? BE0 : BE1);
      end
    end

    // Single m0 read and its return
    do_reset();
    drv(0, 1'b1, 1'b0, 1'b1, A0, D0);
    #3; chk("rd0_t_cs", s.chipselect, 1'b0);
    nxt(); #3;
    chk("rd0_t1_cmd", {s.chipselect, s.read_n, s.write_n}, 3'b101);
    chk("rd0_t1_addr", s.address, 22'h000010);
    chk("rd0_t1_wait0", m0.waitrequest, 1'b0);
    nxt();
    idle_all();
    s.readdatavalid = 1'b1;
    s.readdata      = 32'hDEADBEEF;
    #3;
    chk("rd0_ret_rdv", {m0.readdatavalid, m1.readdatavalid}, 2'b10);
    chk("rd0_ret_data", m0.readdata, 32'hDEADBEEF);
    nxt();
    s.readdatavalid = 1'b0;

    // Continuous requests from both: strict alternation without idle cycles
    do_reset();
    drv(0, 1'b1, 1'b1, 1'b0, A0, D0);
    drv(1, 1'b1, 1'b1, 1'b0, A1, D1);
    #3; chk("alt_idle_cs", s.chipselect, 1'b0);
    for (int k = 0; k < 6; k++) begin
      nxt(); #3;
      chk($sformatf("alt%0d_cs", k), s.chipselect, 1'b1);
      chk($sformatf("alt%0d_addr", k), s.address, (k % 2 == 0) ? A0 : A1);
    end

    // m1 write stalled for 5 cycles while m0 waits, then m0 wins the next tie
    do_reset();
    drv(1, 1'b1, 1'b1, 1'b0, A1, D1);
    s.waitrequest = 1'b1;
    nxt();
    drv(0, 1'b1, 1'b0, 1'b1, A0, D0);
    for (int k = 0; k < 5; k++) begin
      #3;
      chk($sformatf("hold%0d_cmd", k), {s.chipselect, s.read_n, s.write_n}, 3'b110);
      chk($sformatf("hold%0d_addr", k), s.address, A1);
      chk($sformatf("hold%0d_wdata", k), s.writedata, D1);
      chk($sformatf("hold%0d_wait", k), {m0.waitrequest, m1.waitrequest}, 2'b11);
      nxt();
    end
    s.waitrequest = 1'b0;
    #3;
    chk("hold_accept_wait1", m1.waitrequest, 1'b0);
    chk("hold_accept_cs", s.chipselect, 1'b1);
    nxt();
    drv(1, 1'b0, 1'b1, 1'b1, A1, D1);
    #3;
    chk("hold_next_addr", s.address, A0);
    chk("hold_next_wait0", m0.waitrequest, 1'b0);
    idle_all();

    // Tag FIFO full: ninth read stalls until a return has been popped
    do_reset();
    drv(0, 1'b1, 1'b0, 1'b1, A0, D0);
    for (int k = 0; k < 8; k++) begin
      nxt(); #3;
      chk($sformatf("fill%0d_cs", k), s.chipselect, 1'b1);
    end
    nxt(); #3;
    chk("full_cs", s.chipselect, 1'b0);
    chk("full_wait0", m0.waitrequest, 1'b1);
    nxt();
    s.readdatavalid = 1'b1;
    s.readdata      = 32'h1;
    #3;
    chk("full_pop_cs", s.chipselect, 1'b0);
    chk("full_pop_rdv0", m0.readdatavalid, 1'b1);
    nxt();
    s.readdatavalid = 1'b0;
    #3;
    chk("full_release_cs", s.chipselect, 1'b1);
    chk("full_release_wait0", m0.waitrequest, 1'b0);
    idle_all();

    // Interleaved reads routed in order, then an orphan return
    do_reset();
    who[0] = 0; who[1] = 1; who[2] = 1; who[3] = 0;
    dat[0] = 32'hAAAA0000; dat[1] = 32'hBBBB1111; dat[2] = 32'hCCCC2222; dat[3] = 32'hDDDD3333;
    for (int k = 0; k < 4; k++) issue_read(who[k]);
    for (int k = 0; k < 4; k++) begin
      s.readdatavalid = 1'b1;
      s.readdata      = dat[k];
      #3;
      chk($sformatf("ilv%0d_rdv", k), {m0.readdatavalid, m1.readdatavalid}, (who[k] == 0) ? 2'b10 : 2'b01);
      chk($sformatf("ilv%0d_data", k), (who[k] == 0) ? m0.readdata : m1.readdata, dat[k]);
      nxt();
    end
    #3; chk("ilv_orphan_clear", err_orphan, 1'b0);
    #3; chk("orph_rdv", {m0.readdatavalid, m1.readdatavalid}, 2'b00);
    nxt();
    s.readdatavalid = 1'b0;
    #3; chk("orph_flag", err_orphan, 1'b1);
    nxt(); #3; chk("orph_sticky", err_orphan, 1'b1);

    // Reset with three reads outstanding
    do_reset();
    for (int k = 0; k < 3; k++) issue_read(0);
    drv(0, 1'b1, 1'b0, 1'b1, A0, D0);
    s.readdatavalid = 1'b1;
    reset_n = 1'b0;
    #3;
    chk_reset_outputs("midrst");
    idle_all();
    s.readdatavalid = 1'b0;
    nxt();
    reset_n = 1'b1;
    s.readdatavalid = 1'b1;
    #3;
    chk("midrst_rdv", {m0.readdatavalid, m1.readdatavalid}, 2'b00);
    nxt();
    s.readdatavalid = 1'b0;
    #3; chk("midrst_orphan", err_orphan, 1'b1);

    // Random traffic: both masters hold commands until accepted; returns checked against a tag queue
    do_reset();
    q.delete();
    max_age = 0;
    for (int m = 0; m < 2; m++) begin pend[m] = 1'b0; age[m] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1'b1;
          p_rd[m] = 1'($urandom_range(0, 1));
          p_a[m]  = {m[0], 21'($urandom)};
          p_d[m]  = $urandom;
          age[m]  = 0;
        end
        if (pend[m]) drv(m, 1'b1, ~p_rd[m], p_rd[m], p_a[m], p_d[m]);
        else         drv(m, 1'b0, 1'b1, 1'b1, (m == 0) ? A0 : A1, 32'h0);
      end
      s.waitrequest   = ($urandom_range(0, 3) == 0);
      rdv             = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      s.readdatavalid = rdv;
      s.readdata      = $urandom;
      #3;
      acc = s.chipselect && !s.waitrequest;
      if (rdv) begin
        chk("rnd_rdv_route", {m0.readdatavalid, m1.readdatavalid}, (q[0] == 0) ? 2'b10 : 2'b01);
        chk("rnd_rdata", (q[0] == 0) ? m0.readdata : m1.readdata, s.readdata);
      end else begin
        chk("rnd_rdv_quiet", {m0.readdatavalid, m1.readdatavalid}, 2'b00);
      end
      if (acc) chk("rnd_acc_owner_pending", pend[s.address[21]], 1'b1);
      for (int m = 0; m < 2; m++) begin
        if (pend[m]) begin
          exp_done = acc && (s.address[21] == m[0]);
          chk("rnd_wait", wait_of(m), !exp_done);
          if (exp_done) begin
            chk("rnd_addr", s.address, p_a[m]);
            chk("rnd_strobes", {s.read_n, s.write_n}, p_rd[m] ? 2'b01 : 2'b10);
            if (!p_rd[m]) chk("rnd_wdata", s.writedata, p_d[m]);
            else          chk("rnd_not_full", q.size() < DEPTH, 1'b1);
          end
        end
      end
      if (rdv) void'(q.pop_front());
      for (int m = 0; m < 2; m++) begin
        if (pend[m]) begin
          if (acc && (s.address[21] == m[0])) begin
            if (p_rd[m]) q.push_back(m);
            pend[m] = 1'b0;
          end else begin
            age[m]++;
            if (age[m] > max_age) max_age = age[m];
          end
        end
      end
      nxt();
    end
    chk("rnd_no_starvation", max_age < 200, 1'b1);
    chk("rnd_no_orphan", err_orphan, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
